// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
// Shared constants for the multi-channel LED PWM fader: register word
// offsets, bit positions inside CTRL/STATUS, default parameter values and
// helpers that map a channel index to its TARGET/CURRENT word addresses.
// -----------------------------------------------------------------------------
package led_pwm_pkg;

    // Default parameter values
    localparam int DEF_NUM_CH     = 3;
    localparam int DEF_DUTY_W     = 8;
    localparam int DEF_PRESCALE_W = 16;
    localparam int DEF_ADDR_W     = 4;

    // Register word offsets
    localparam int REG_CTRL      = 0;
    localparam int REG_STATUS    = 1;
    localparam int REG_PRESCALE  = 2;
    localparam int REG_FADE_RATE = 3;
    localparam int CH_BASE       = 4;
    localparam int CH_STRIDE     = 2;

    // Register field positions / widths
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_IRQ_BIT  = 16;
    localparam int FADE_RATE_W     = 16;

    // Each channel owns two consecutive words: TARGET then CURRENT.
    function automatic int ch_target_addr(input int ch);
        return CH_BASE + CH_STRIDE * ch;
    endfunction

    function automatic int ch_current_addr(input int ch);
        return CH_BASE + CH_STRIDE * ch + 1;
    endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// -----------------------------------------------------------------------------
// led_pwm_fader_if
// Avalon-MM slave bundle for the LED PWM fader.
//   address    : word address (ADDR_W bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, driven by the slave
// -----------------------------------------------------------------------------
interface led_pwm_fader_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/led_pwm_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
// One PWM channel: CURRENT/TARGET registers, the +/-1 fade stepper, the
// active-duty shadow (only reloaded at period end or while disabled) and the
// registered PWM comparator.
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : global enable from CTRL
//   period_end     : PWM counter wraps on this cycle
//   fade_step      : global fade step strobe
//   wr_current     : CPU write to CURRENT (also loads TARGET)
//   wr_target      : CPU write to TARGET
//   wdata          : truncated write data
//   pwm_cnt        : shared PWM counter
//   current/target : register contents for readback
//   busy           : CURRENT != TARGET
//   reached        : pulse, this cycle's fade step lands on TARGET
//   pwm_out        : registered PWM output
// -----------------------------------------------------------------------------
module led_pwm_channel #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              period_end,
    input  logic              fade_step,
    input  logic              wr_current,
    input  logic              wr_target,
    input  logic [DUTY_W-1:0] wdata,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic [DUTY_W-1:0] current,
    output logic [DUTY_W-1:0] target,
    output logic              busy,
    output logic              reached,
    output logic              pwm_out
);

    logic [DUTY_W-1:0] active;
    logic [DUTY_W-1:0] next_cur;
    logic              step_here;

    assign busy      = (current != target);
    // A CPU write to either register on a step cycle wins; the channel skips.
    assign step_here = fade_step && busy && !wr_current && !wr_target;
    assign next_cur  = (current < target) ? current + 1'b1 : current - 1'b1;
    assign reached   = step_here && (next_cur == target);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current <= '0;
            target  <= '0;
        end else if (wr_current) begin
            current <= wdata;
            target  <= wdata;
        end else begin
            if (wr_target) target  <= wdata;
            if (step_here) current <= next_cur;
        end
    end

    // Shadow duty only changes on a period boundary, so a period is never cut.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (!enable || period_end) active <= current;
            pwm_out <= enable && (pwm_cnt < active);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
// Multi-channel LED PWM driver with hardware fade engine on Avalon-MM.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n,
//                  writedata, readdata)
//   pwm_out      : registered PWM outputs, one per channel
//   irq          : level interrupt, irq_pending & irq_en
// Holds bus decode, read mux, tick prescaler, PWM counter, fade-rate counter
// and interrupt state; per-channel datapath lives in led_pwm_channel.
// -----------------------------------------------------------------------------
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DUTY_W     = DEF_DUTY_W,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    led_pwm_fader_if.slave    bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    logic [ADDR_W-1:0]     addr;
    logic                  wr_en;
    logic                  wr_ctrl, wr_status, wr_prescale, wr_fade_rate;

    logic                  enable;
    logic                  irq_en;
    logic                  irq_pending;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] ps_cnt;
    logic [FADE_RATE_W-1:0] fade_rate;
    logic [FADE_RATE_W-1:0] rate_cnt;
    logic [DUTY_W-1:0]     pwm_cnt;

    logic                  tick;
    logic                  period_end;
    logic                  fade_step;

    logic [NUM_CH-1:0]     busy;
    logic [NUM_CH-1:0]     reached;
    logic [NUM_CH-1:0]     wr_cur;
    logic [NUM_CH-1:0]     wr_tgt;
    logic [DUTY_W-1:0]     cur_val [NUM_CH];
    logic [DUTY_W-1:0]     tgt_val [NUM_CH];
    logic [31:0]           rdata;
    logic                  unused_wdata;

    // ---------------- bus decode ----------------
    assign addr         = bus.address;
    assign wr_en        = bus.chipselect && !bus.write_n;
    assign wr_ctrl      = wr_en && (addr == ADDR_W'(REG_CTRL));
    assign wr_status    = wr_en && (addr == ADDR_W'(REG_STATUS));
    assign wr_prescale  = wr_en && (addr == ADDR_W'(REG_PRESCALE));
    assign wr_fade_rate = wr_en && (addr == ADDR_W'(REG_FADE_RATE));
    // Most registers keep only the low bits of writedata.
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            prescale  <= '0;
            fade_rate <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= bus.writedata[CTRL_ENABLE_BIT];
                irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
            end
            if (wr_prescale)  prescale  <= bus.writedata[PRESCALE_W-1:0];
            if (wr_fade_rate) fade_rate <= bus.writedata[FADE_RATE_W-1:0];
        end
    end

    // ---------------- timebase ----------------
    assign tick       = enable && (ps_cnt == prescale);
    assign period_end = tick && (pwm_cnt == '1);
    assign fade_step  = period_end && (rate_cnt == fade_rate);

    // All counters sit at 0 while disabled so re-enabling starts a clean period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_cnt   <= '0;
            pwm_cnt  <= '0;
            rate_cnt <= '0;
        end else if (!enable) begin
            ps_cnt   <= '0;
            pwm_cnt  <= '0;
            rate_cnt <= '0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            if (tick)       pwm_cnt  <= pwm_cnt + 1'b1;
            if (period_end) rate_cnt <= fade_step ? '0 : rate_cnt + 1'b1;
        end
    end

    // ---------------- interrupt ----------------
    // A completion in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending <= 1'b0;
        end else if (|reached) begin
            irq_pending <= 1'b1;
        end else if (wr_status && bus.writedata[STATUS_IRQ_BIT]) begin
            irq_pending <= 1'b0;
        end
    end

    assign irq = irq_pending && irq_en;

    // ---------------- channels ----------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_tgt[i] = wr_en && (addr == ADDR_W'(ch_target_addr(i)));
        assign wr_cur[i] = wr_en && (addr == ADDR_W'(ch_current_addr(i)));

        led_pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (enable),
            .period_end (period_end),
            .fade_step  (fade_step),
            .wr_current (wr_cur[i]),
            .wr_target  (wr_tgt[i]),
            .wdata      (bus.writedata[DUTY_W-1:0]),
            .pwm_cnt    (pwm_cnt),
            .current    (cur_val[i]),
            .target     (tgt_val[i]),
            .busy       (busy[i]),
            .reached    (reached[i]),
            .pwm_out    (pwm_out[i])
        );
    end

    // ---------------- read mux ----------------
    // NOTE: rdata gets a default before any branch so no path can infer a latch.
    always_comb begin
        rdata = '0;
        if (addr == ADDR_W'(REG_CTRL)) begin
            rdata[CTRL_ENABLE_BIT] = enable;
            rdata[CTRL_IRQ_EN_BIT] = irq_en;
        end else if (addr == ADDR_W'(REG_STATUS)) begin
            rdata[NUM_CH-1:0]     = busy;
            rdata[STATUS_IRQ_BIT] = irq_pending;
        end else if (addr == ADDR_W'(REG_PRESCALE)) begin
            rdata[PRESCALE_W-1:0] = prescale;
        end else if (addr == ADDR_W'(REG_FADE_RATE)) begin
            rdata[FADE_RATE_W-1:0] = fade_rate;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(ch_target_addr(i)))  rdata[DUTY_W-1:0] = tgt_val[i];
            if (addr == ADDR_W'(ch_current_addr(i))) rdata[DUTY_W-1:0] = cur_val[i];
        end
    end

    assign bus.readdata = rdata;

endmodule
